saturating_branch_predictor: RTL and testbench
==============================================

# saturating_branch_predictor

Table-based branch direction predictor: generalises the single-bit-per-address predictor to a 2^ADDR_WIDTH-entry table of CTR_WIDTH-bit saturating counters. Prediction lookup and outcome update use separate ports, and a mispredict statistics counter is included. It sits in the fetch stage next to the PC, and is updated from execute once the branch resolves. An optional gshare mode folds a global history register into the index.

## Interface
- ADDR_WIDTH, 4, table index width; depth = 2^ADDR_WIDTH entries
- CTR_WIDTH, 2, counter width per entry; legal range 1..4
- HIST_WIDTH, 4, global history length; used only with gshare; must be ≤ ADDR_WIDTH
- STAT_WIDTH, 16, width of mispredict counter
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- branch_address  input  ADDR_WIDTH  lookup index (low PC bits) for the branch being fetched
- prediction  output  1  predicted direction for branch_address; 1 = taken
- confidence  output  CTR_WIDTH  raw counter value behind prediction
- update_valid  input  1  qualifies an update this cycle
- update_address  input  ADDR_WIDTH  index of the resolved branch
- branch_result  input  1  actual outcome of resolved branch; 1 = taken
- mispredict_count  output  STAT_WIDTH  number of updates whose stored prediction disagreed with branch_result

## Operation
- Counter encoding: unsigned; prediction = counter MSB.
- Reset value of every entry: WEAK_NT = 2^(CTR_WIDTH-1) - 1 (2'b01 for default; 0 for CTR_WIDTH=1).
- Lookup is combinational from registered table state: prediction/confidence follow branch_address in the same cycle.
- Update when update_valid=1:
  - branch_result=1 → entry increments, saturating at 2^CTR_WIDTH - 1.
  - branch_result=0 → entry decrements, saturating at 0.
- update_valid=0: table, history and statistics hold.
- Mispredict stats: on update_valid, if the MSB of the pre-update entry ≠ branch_result, mispredict_count increments, saturating at all-ones (no wrap).
- Indexing without gshare: lookup index = branch_address; update index = update_address.
- Only one update per cycle; no update queue. Updates with update_valid=0 are ignored irrespective of other inputs.

## Timing
- rst=1 at rising edge: all entries → WEAK_NT, history → 0, mispredict_count → 0. After the reset cycle: prediction=0 and confidence=WEAK_NT for any address.
- rst dominates update_valid in the same cycle. Reset mid-sequence discards all trained state.
- Update latency: the entry written at edge N is visible on prediction from edge N onward, i.e. the next cycle.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update value (no bypass).
- Saturation boundaries: increment at max and decrement at 0 leave the entry unchanged; a mispredict is still counted.

## Configuration
- PREDICTOR_GSHARE_EN defined:
  - A HIST_WIDTH-bit global history register, reset 0, shifts in branch_result at LSB on each update_valid.
  - Lookup index = branch_address XOR zero-extended history.
  - Update index = update_address XOR history value before this update's shift.
- PREDICTOR_GSHARE_EN undefined: no history register, direct indexing; HIST_WIDTH unused.

## Structure
- Shared package predictor_pkg holds:
  - counter typedef parametrised by CTR_WIDTH
  - WEAK_NT reset constant function
  - saturating inc/dec function
- One sub-module, predictor_sat_counter: next-state logic (value, taken) → saturated value plus mispredict flag. It is instantiated once, on the update path.
- The table is a register array, so reset clears it in a single cycle; no RAM macro is used.

## Test plan
- Reset: pulse rst one cycle, sweep branch_address 0..15 → prediction=0, confidence=1, mispredict_count=0 everywhere.
- Training: 3 updates to address 0 with result 1 → confidence 2 then 3 then 3 (saturated). prediction=1 after the first update. mispredict_count=1.
- Decay and saturation at 0: from 3, 4 updates with result 0 → confidence 2,1,0,0. mispredict_count increments only on the updates where the MSB was 1 or predicted differently (check: +2).
- Same-cycle hazard: lookup 5 while updating 5 taken from WEAK_NT → prediction 0 that cycle, 1 the next. Other indexes are unchanged.
- Stats saturation with STAT_WIDTH=2: 5 consecutive mispredicts → mispredict_count stops at 3. Then rst mid-run → all state returns to reset values the next cycle.
- With PREDICTOR_GSHARE_EN, after updates taken,taken (history=4'b0011): lookup address 4'b0011 reads entry 0. An update at address 4'b0001 writes entry 4'b0010.

Source files
------------

// File: rtl/predictor_pkg.sv
// Shared types and counter helpers for the saturating branch predictor.
// Counters are carried in a MAX_CTR_WIDTH-wide container; callers slice to CTR_WIDTH.
package predictor_pkg;

  localparam int unsigned MAX_CTR_WIDTH = 4;

  typedef logic [MAX_CTR_WIDTH-1:0] ctr_t;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } dir_e;

  // Weakly-not-taken value: just below the taken threshold.
  function automatic ctr_t weak_nt(input int unsigned w);
    return ctr_t'((1 << (w - 1)) - 1);
  endfunction

  function automatic ctr_t ctr_max(input int unsigned w);
    return ctr_t'((1 << w) - 1);
  endfunction

  // One saturating step: up toward ctr_max(w), down toward zero.
  function automatic ctr_t sat_step(input ctr_t v, input int unsigned w, input logic up);
    ctr_t r;
    r = v;
    if (up) begin
      if (v != ctr_max(w)) r = v + 1'b1;
    end else begin
      if (v != '0) r = v - 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/saturating_branch_predictor_if.sv
// Lookup/update/statistics bundle between fetch/execute and the predictor.
interface saturating_branch_predictor_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CTR_WIDTH  = 2,
  parameter int unsigned STAT_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] branch_address;
  logic                  prediction;
  logic [CTR_WIDTH-1:0]  confidence;
  logic                  update_valid;
  logic [ADDR_WIDTH-1:0] update_address;
  logic                  branch_result;
  logic [STAT_WIDTH-1:0] mispredict_count;

  modport master (
    output branch_address, update_valid, update_address, branch_result,
    input  prediction, confidence, mispredict_count
  );

  modport slave (
    input  branch_address, update_valid, update_address, branch_result,
    output prediction, confidence, mispredict_count
  );
endinterface

// File: rtl/predictor_sat_counter.sv
// Next-state logic for one table entry: saturated step plus mispredict flag.
module predictor_sat_counter
  import predictor_pkg::*;
#(
  parameter int unsigned CTR_WIDTH = 2
) (
  input  logic [CTR_WIDTH-1:0] value,
  input  logic                 taken,
  output logic [CTR_WIDTH-1:0] next_value,
  output logic                 mispredict
);

  ctr_t value_ext;
  ctr_t step_ext;

  // Step the counter toward the outcome and compare its MSB with it.
  always_comb begin
    value_ext  = ctr_t'(value);
    step_ext   = sat_step(value_ext, CTR_WIDTH, taken);
    next_value = step_ext[CTR_WIDTH-1:0];
    mispredict = (dir_e'(value[CTR_WIDTH-1]) != dir_e'(taken));
  end

endmodule

// File: rtl/saturating_branch_predictor.sv
// Table of saturating counters with separate lookup/update ports and a
// saturating mispredict counter. Optional gshare indexing: PREDICTOR_GSHARE_EN.
module saturating_branch_predictor
  import predictor_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CTR_WIDTH  = 2,
  parameter int unsigned HIST_WIDTH = 4,
  parameter int unsigned STAT_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  saturating_branch_predictor_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam ctr_t RESET_EXT = weak_nt(CTR_WIDTH);
  localparam logic [CTR_WIDTH-1:0] RESET_VAL = RESET_EXT[CTR_WIDTH-1:0];

  logic [CTR_WIDTH-1:0]  table_q [DEPTH];
  logic [ADDR_WIDTH-1:0] lookup_idx;
  logic [ADDR_WIDTH-1:0] update_idx;
  logic [CTR_WIDTH-1:0]  lookup_value;
  logic [CTR_WIDTH-1:0]  upd_value;
  logic [CTR_WIDTH-1:0]  upd_next;
  logic                  upd_mispredict;
  logic [STAT_WIDTH-1:0] stat_q;

`ifdef PREDICTOR_GSHARE_EN
  logic [HIST_WIDTH-1:0] hist_q;

  // Fold global history into both indexes; update uses pre-shift history.
  always_comb begin
    lookup_idx = bus.branch_address ^ ADDR_WIDTH'(hist_q);
    update_idx = bus.update_address ^ ADDR_WIDTH'(hist_q);
  end

  // Shift each resolved outcome into the history LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
    end else if (bus.update_valid) begin
      hist_q <= (hist_q << 1) | HIST_WIDTH'(bus.branch_result);
    end
  end
`else
  // Direct indexing by the low PC bits.
  always_comb begin
    lookup_idx = bus.branch_address;
    update_idx = bus.update_address;
  end
`endif

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  always_comb begin
    lookup_value     = table_q[lookup_idx];
    upd_value        = table_q[update_idx];
    bus.confidence   = lookup_value;
    bus.prediction   = lookup_value[CTR_WIDTH-1];
    bus.mispredict_count = stat_q;
  end

  predictor_sat_counter #(
    .CTR_WIDTH(CTR_WIDTH)
  ) u_sat_counter (
    .value     (upd_value),
    .taken     (bus.branch_result),
    .next_value(upd_next),
    .mispredict(upd_mispredict)
  );

  // Counter table: whole-table reset, one entry written per qualified update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        table_q[i] <= RESET_VAL;
      end
    end else if (bus.update_valid) begin
      table_q[update_idx] <= upd_next;
    end
  end

  // Mispredict statistics, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q <= '0;
    end else if (bus.update_valid && upd_mispredict && (stat_q != '1)) begin
      stat_q <= stat_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_saturating_branch_predictor.sv
// Directed bench for saturating_branch_predictor (gshare checks with PREDICTOR_GSHARE_EN).
module tb_saturating_branch_predictor;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  saturating_branch_predictor_if #(.ADDR_WIDTH(4), .CTR_WIDTH(2), .STAT_WIDTH(16)) if_a ();
  saturating_branch_predictor_if #(.ADDR_WIDTH(4), .CTR_WIDTH(2), .STAT_WIDTH(2))  if_b ();

  saturating_branch_predictor #(
    .ADDR_WIDTH(4), .CTR_WIDTH(2), .HIST_WIDTH(4), .STAT_WIDTH(16)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave)
  );

  saturating_branch_predictor #(
    .ADDR_WIDTH(4), .CTR_WIDTH(2), .HIST_WIDTH(4), .STAT_WIDTH(2)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic update_a(input logic [3:0] addr, input logic res);
    if_a.update_valid   = 1'b1;
    if_a.update_address = addr;
    if_a.branch_result  = res;
    tick();
    if_a.update_valid   = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if_a.branch_address = 4'(i);
      #1;
      checks++;
      if (if_a.prediction !== 1'b0) begin
        errors++;
        $display("FAIL reset_pred addr=%0d got=%0b exp=0", i, if_a.prediction);
      end
      checks++;
      if (if_a.confidence !== 2'd1) begin
        errors++;
        $display("FAIL reset_conf addr=%0d got=%0d exp=1", i, if_a.confidence);
      end
    end
    checks++;
    if (if_a.mispredict_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_stat got=%0d exp=0", if_a.mispredict_count);
    end
  endtask

  task automatic test_training();
    logic [1:0] exp_conf [3];
    exp_conf[0] = 2'd2; exp_conf[1] = 2'd3; exp_conf[2] = 2'd3;
    if_a.branch_address = 4'd0;
    for (int i = 0; i < 3; i++) begin
      update_a(4'd0, 1'b1);
      checks++;
      if (if_a.confidence !== exp_conf[i]) begin
        errors++;
        $display("FAIL train_conf step=%0d got=%0d exp=%0d", i, if_a.confidence, exp_conf[i]);
      end
      checks++;
      if (if_a.prediction !== 1'b1) begin
        errors++;
        $display("FAIL train_pred step=%0d got=%0b exp=1", i, if_a.prediction);
      end
    end
    checks++;
    if (if_a.mispredict_count !== 16'd1) begin
      errors++;
      $display("FAIL train_stat got=%0d exp=1", if_a.mispredict_count);
    end
  endtask

  task automatic test_decay();
    logic [1:0] exp_conf [4];
    exp_conf[0] = 2'd2; exp_conf[1] = 2'd1; exp_conf[2] = 2'd0; exp_conf[3] = 2'd0;
    if_a.branch_address = 4'd0;
    for (int i = 0; i < 4; i++) begin
      update_a(4'd0, 1'b0);
      checks++;
      if (if_a.confidence !== exp_conf[i]) begin
        errors++;
        $display("FAIL decay_conf step=%0d got=%0d exp=%0d", i, if_a.confidence, exp_conf[i]);
      end
    end
    checks++;
    if (if_a.prediction !== 1'b0) begin
      errors++;
      $display("FAIL decay_pred got=%0b exp=0", if_a.prediction);
    end
    checks++;
    if (if_a.mispredict_count !== 16'd3) begin
      errors++;
      $display("FAIL decay_stat got=%0d exp=3", if_a.mispredict_count);
    end
  endtask

  task automatic test_hazard();
    if_a.branch_address = 4'd5;
    if_a.update_valid   = 1'b1;
    if_a.update_address = 4'd5;
    if_a.branch_result  = 1'b1;
    #1;
    checks++;
    if (if_a.prediction !== 1'b0 || if_a.confidence !== 2'd1) begin
      errors++;
      $display("FAIL hazard_same_cycle got=%0b/%0d exp=0/1", if_a.prediction, if_a.confidence);
    end
    tick();
    if_a.update_valid = 1'b0;
    #1;
    checks++;
    if (if_a.prediction !== 1'b1 || if_a.confidence !== 2'd2) begin
      errors++;
      $display("FAIL hazard_next_cycle got=%0b/%0d exp=1/2", if_a.prediction, if_a.confidence);
    end
    if_a.branch_address = 4'd4;
    #1;
    checks++;
    if (if_a.confidence !== 2'd1) begin
      errors++;
      $display("FAIL hazard_neighbour4 got=%0d exp=1", if_a.confidence);
    end
    if_a.branch_address = 4'd6;
    #1;
    checks++;
    if (if_a.confidence !== 2'd1) begin
      errors++;
      $display("FAIL hazard_neighbour6 got=%0d exp=1", if_a.confidence);
    end
    checks++;
    if (if_a.mispredict_count !== 16'd4) begin
      errors++;
      $display("FAIL hazard_stat got=%0d exp=4", if_a.mispredict_count);
    end
  endtask

  task automatic test_hold();
    if_a.update_valid   = 1'b0;
    if_a.update_address = 4'd0;
    if_a.branch_result  = 1'b1;
    tick();
    tick();
    if_a.branch_address = 4'd0;
    #1;
    checks++;
    if (if_a.confidence !== 2'd0) begin
      errors++;
      $display("FAIL hold_conf got=%0d exp=0", if_a.confidence);
    end
    checks++;
    if (if_a.mispredict_count !== 16'd4) begin
      errors++;
      $display("FAIL hold_stat got=%0d exp=4", if_a.mispredict_count);
    end
  endtask

  task automatic test_stat_saturation();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
    exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    if_b.branch_address = 4'd1;
    for (int i = 0; i < 5; i++) begin
      if_b.update_valid   = 1'b1;
      if_b.update_address = 4'd1;
      if_b.branch_result  = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      if_b.update_valid = 1'b0;
      #1;
      checks++;
      if (if_b.mispredict_count !== exp_cnt[i]) begin
        errors++;
        $display("FAIL stat_sat step=%0d got=%0d exp=%0d", i, if_b.mispredict_count, exp_cnt[i]);
      end
    end
  endtask

  task automatic test_gshare();
`ifdef PREDICTOR_GSHARE_EN
    update_a(4'd0, 1'b1);
    update_a(4'd0, 1'b1);
    if_a.branch_address = 4'b0011;
    #1;
    checks++;
    if (if_a.confidence !== 2'd2) begin
      errors++;
      $display("FAIL gshare_entry0 got=%0d exp=2", if_a.confidence);
    end
    update_a(4'b0001, 1'b1);
    // history is now 4'b0111: entry 2 is read via address 5, entry 3 via address 4
    if_a.branch_address = 4'd5;
    #1;
    checks++;
    if (if_a.confidence !== 2'd2) begin
      errors++;
      $display("FAIL gshare_entry2 got=%0d exp=2", if_a.confidence);
    end
    if_a.branch_address = 4'd4;
    #1;
    checks++;
    if (if_a.confidence !== 2'd1) begin
      errors++;
      $display("FAIL gshare_entry3 got=%0d exp=1", if_a.confidence);
    end
`endif
  endtask

  task automatic test_reset_mid();
    if_a.update_valid   = 1'b1;
    if_a.update_address = 4'd0;
    if_a.branch_result  = 1'b1;
    if_b.update_valid   = 1'b1;
    if_b.update_address = 4'd1;
    if_b.branch_result  = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_a.update_valid = 1'b0;
    if_b.update_valid = 1'b0;
    if_a.branch_address = 4'd0;
    if_b.branch_address = 4'd1;
    #1;
    checks++;
    if (if_a.mispredict_count !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_stat_a got=%0d exp=0", if_a.mispredict_count);
    end
    checks++;
    if (if_b.mispredict_count !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_stat_b got=%0d exp=0", if_b.mispredict_count);
    end
    checks++;
    if (if_a.confidence !== 2'd1 || if_a.prediction !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_entry_a got=%0d/%0b exp=1/0", if_a.confidence, if_a.prediction);
    end
    checks++;
    if (if_b.confidence !== 2'd1) begin
      errors++;
      $display("FAIL rstmid_entry_b got=%0d exp=1", if_b.confidence);
    end
    if_a.branch_address = 4'd5;
    #1;
    checks++;
    if (if_a.confidence !== 2'd1) begin
      errors++;
      $display("FAIL rstmid_entry5 got=%0d exp=1", if_a.confidence);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    if_a.branch_address = '0;
    if_a.update_valid   = 1'b0;
    if_a.update_address = '0;
    if_a.branch_result  = 1'b0;
    if_b.branch_address = '0;
    if_b.update_valid   = 1'b0;
    if_b.update_address = '0;
    if_b.branch_result  = 1'b0;
    tick();
    test_reset();
`ifdef PREDICTOR_GSHARE_EN
    test_gshare();
`else
    test_training();
    test_decay();
    test_hazard();
    test_hold();
    test_stat_saturation();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
